alu_seq: RTL and testbench

- Parametrised, registered successor of the team's 4-bit combinational ALU with Z/N/C/V flags.
- Widens the datapath to WIDTH bits and adds XOR, carry-chained ADC/SBB and an iterative multiply.
- Holds a persistent flag register between operations.
- Sits between an operand source and a result sink, with valid/ready handshakes on both sides.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mul_seq.sv | 57 +++++
 rtl/alu_seq.sv | 127 ++++++++++++
 tb/tb_alu_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcode encoding, flag bit positions
// and the controller state encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_ADC = 3'b101,
        OP_SBB = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // Two-bit encoding leaves spare codes; the controller maps them back to IDLE.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MUL_BUSY = 2'b01
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles
// per operation. prod is valid in the cycle where done is high.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    // The final partial product is folded in combinationally so the owner can
    // register the full product on the last step edge.
    assign done = busy && (cnt == CW'(1));
    assign prod = acc_next;

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with persistent Z/N/C/V flags, valid/ready on both sides and
// an iterative multiply. Define ALU_SAT_EN to saturate ADD/ADC/SUB/SBB on signed overflow.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds its data stable from raising valid until that edge.
    state_e             state;
    logic               accept;
    logic               start_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH:0]     ext_a, ext_b, ext_c, res;
    logic               c_out, v_out;
    logic [WIDTH-1:0]   alu_y, mul_y;
    logic [3:0]         alu_flags, mul_flags;

    assign in_ready  = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && (op_e'(op) == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_mul),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (prod)
    );

    always_comb begin
        ext_a = {1'b0, a};
        ext_b = {1'b0, b};
        ext_c = {{WIDTH{1'b0}}, flags[FLG_C]};
        res   = '0;
        c_out = 1'b0;
        v_out = 1'b0;
        case (op_e'(op))
            OP_ADD, OP_ADC: begin
                res   = (op_e'(op) == OP_ADC) ? (ext_a + ext_b + ext_c) : (ext_a + ext_b);
                c_out = res[WIDTH];
                v_out = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                res   = (op_e'(op) == OP_SBB) ? (ext_a - ext_b - ext_c) : (ext_a - ext_b);
                c_out = res[WIDTH];
                v_out = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res = {1'b0, a & b};
            OP_OR:   res = {1'b0, a | b};
            OP_XOR:  res = {1'b0, a ^ b};
            default: res = '0;
        endcase
        alu_y = res[WIDTH-1:0];
`ifdef ALU_SAT_EN
        // Overflow direction follows the sign of a for both add and subtract.
        if (v_out) begin
            alu_y = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
`endif
        alu_flags        = '0;
        alu_flags[FLG_Z] = (alu_y == '0);
        alu_flags[FLG_N] = alu_y[WIDTH-1];
        alu_flags[FLG_C] = c_out;
        alu_flags[FLG_V] = v_out;

        mul_y            = prod[WIDTH-1:0];
        mul_flags        = '0;
        mul_flags[FLG_Z] = (mul_y == '0);
        mul_flags[FLG_N] = mul_y[WIDTH-1];
        mul_flags[FLG_C] = |prod[2*WIDTH-1:WIDTH];
        mul_flags[FLG_V] = |prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            y         <= '0;
            flags     <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_mul) begin
                        state <= MUL_BUSY;
                    end else if (accept) begin
                        y         <= alu_y;
                        flags     <= alu_flags;
                        out_valid <= 1'b1;
                    end
                end
                MUL_BUSY: begin
                    if (mul_done) begin
                        y         <= mul_y;
                        flags     <= mul_flags;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table for the single-result path plus
// hand-written sequences for multiply latency, backpressure and reset during multiply.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [3:0]   flags;

    int checks = 0;
    int errors = 0;

    logic [W+3:0] exp_q[$];

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic [3:0]   f;
    } vec_t;

    vec_t vecs[16];

    alu_seq #(.WIDTH(W), .OPW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: presents one operation and returns just after the accepting edge
    task automatic send(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
        int n;
        @(negedge clk);
        op = o; a = aa; b = bb; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 30) begin
            @(negedge clk);
            ok = out_valid;
            n++;
        end
    endtask

    initial begin
        bit           ok;
        logic [W+3:0] e;
        logic [3:0]   last_f;

        // op a b y flags{Z,N,C,V}
        vecs[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b0101};
`ifdef ALU_SAT_EN
        vecs[0]  = '{3'b000, 8'h7F, 8'h01, 8'h7F, 4'b0001};
`endif
        vecs[1]  = '{3'b001, 8'h00, 8'h01, 8'hFF, 4'b0110};
        vecs[2]  = '{3'b110, 8'h05, 8'h01, 8'h03, 4'b0000};
        vecs[3]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b1010};
        vecs[4]  = '{3'b101, 8'h00, 8'h00, 8'h01, 4'b0000};
        vecs[5]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000};
        vecs[6]  = '{3'b011, 8'h80, 8'h01, 8'h81, 4'b0100};
        vecs[7]  = '{3'b100, 8'hAA, 8'hAA, 8'h00, 4'b1000};
        vecs[8]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b0001};
`ifdef ALU_SAT_EN
        vecs[8]  = '{3'b001, 8'h80, 8'h01, 8'h80, 4'b0101};
`endif
        vecs[9]  = '{3'b001, 8'h00, 8'h01, 8'hFF, 4'b0110};
        vecs[10] = '{3'b101, 8'hFF, 8'h00, 8'h00, 4'b1010};
        vecs[11] = '{3'b110, 8'h00, 8'h00, 8'hFF, 4'b0110};
        vecs[12] = '{3'b000, 8'h80, 8'h80, 8'h00, 4'b1011};
`ifdef ALU_SAT_EN
        vecs[12] = '{3'b000, 8'h80, 8'h80, 8'h80, 4'b0111};
`endif
        vecs[13] = '{3'b111, 8'h0F, 8'h0F, 8'hE1, 4'b0100};
        vecs[14] = '{3'b111, 8'hFF, 8'hFF, 8'h01, 4'b0011};
        vecs[15] = '{3'b111, 8'h00, 8'hFF, 8'h00, 4'b1000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_y", 32'(y), 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);

        // single-cycle and multiply results, flags carried between vectors
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            exp_q.push_back({vecs[i].y, vecs[i].f});
            wait_out(ok);
            check($sformatf("vec%0d_out_valid", i), 32'(ok), 32'd1);
            e = exp_q.pop_front();
            check($sformatf("vec%0d_y", i), 32'(y), 32'(e[W+3:4]));
            check($sformatf("vec%0d_flags", i), 32'(flags), 32'(e[3:0]));
        end
        last_f = vecs[15].f;

        // multiply latency: busy for W cycles, result visible on cycle W+1
        send(3'b111, 8'h10, 8'h11);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            check($sformatf("mul_busy%0d_in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("mul_busy%0d_out_valid", i), 32'(out_valid), 32'd0);
            check($sformatf("mul_busy%0d_flags", i), 32'(flags), 32'(last_f));
        end
        @(negedge clk);
        check("mul_lat_out_valid", 32'(out_valid), 32'd1);
        check("mul_lat_y", 32'(y), 32'h10);
        check("mul_lat_flags", 32'(flags), 32'b0011);

        // backpressure: result held, second op stalled, then back-to-back hand-off
        @(negedge clk);
        out_ready = 1'b0;
        send(3'b000, 8'h01, 8'h02);
        @(negedge clk);
        op = 3'b100; a = 8'h0F; b = 8'hF0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_y", i), 32'(y), 32'h03);
            check($sformatf("bp%0d_flags", i), 32'(flags), 32'b0000);
            check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_b2b_out_valid", 32'(out_valid), 32'd1);
        check("bp_b2b_y", 32'(y), 32'hFF);
        check("bp_b2b_flags", 32'(flags), 32'b0100);
        @(negedge clk);
        check("bp_drain_out_valid", 32'(out_valid), 32'd0);

        // reset during the 4th multiply cycle
        send(3'b111, 8'h10, 8'h11);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_flags", 32'(flags), 32'd0);
        check("midrst_y", 32'(y), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        check("postrst_no_stale", 32'(ok), 32'd0);
        send(3'b101, 8'h01, 8'h01);
        wait_out(ok);
        check("postrst_adc_valid", 32'(ok), 32'd1);
        check("postrst_adc_y", 32'(y), 32'h02);
        check("postrst_adc_flags", 32'(flags), 32'b0000);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
